// File: rtl/pool_map_reader.sv
// Streams the pooled feature map out of the L2 output BRAM over valid/ready,
// using a 2-entry FIFO and credit-limited reads. Define POOL_READER_RELU_EN to apply ReLU on read.
module pool_map_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int MAP_DIM    = 14,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int NUM_ELEMS = MAP_DIM * MAP_DIM;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         rd_cnt;
  logic [ADDR_WIDTH-1:0]         out_cnt;
  logic                          inflight;
  logic [1:0]                    fifo_count;
  logic                          wr_ptr;
  logic                          rd_ptr;
  logic signed [DATA_WIDTH-1:0]  fifo_mem [2];
  logic signed [DATA_WIDTH-1:0]  din_p1;
  logic                          pop;
  logic [2:0]                    credit_used;

`ifdef POOL_READER_RELU_EN
  function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  assign din_p1 = relu(signed'(ram_dout));
`else
  assign din_p1 = signed'(ram_dout);
`endif

  // Credits: buffered entries plus the read in flight, less the entry leaving now.
  assign pop         = out_valid & out_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign ram_en      = (state == READ) && (credit_used < 3'd2);
  assign ram_addr    = rd_cnt;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last  = out_valid && (out_cnt == LAST_IDX);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight   <= ram_en;
      done       <= 1'b0;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            rd_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        READ: begin
          if (ram_en) begin
            if (rd_cnt == LAST_IDX) state <= DRAIN;
            else                    rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after issue; the write is gated only by inflight.
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= din_p1;
  end

endmodule

// File: tb/tb_pool_map_reader.sv
// Scoreboard bench for pool_map_reader: BRAM model, directed streams, backpressure, restart and reset cases.
module tb_pool_map_reader;
  localparam int DW = 16;
  localparam int MD = 14;
  localparam int AW = 8;
  localparam int N  = MD * MD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic [DW-1:0] mem [256];
  exp_t          sb [$];
  exp_t          mon_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int s_cyc = 0;
  int first_valid_cyc = -1;
  int done_cyc = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int issue_idx = 0;
  int outstanding = 0;
  int rmode = 0;
  logic          busy_at_done = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [7:0]    lfsr = 8'hA5;

  pool_map_reader #(.DATA_WIDTH(DW), .MAP_DIM(MD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  always @(posedge clk) begin
    #1;
    if (rmode == 1) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_ready = lfsr[0];
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks addresses, credit and stall hold.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (ram_en) begin
        check("ram_addr", longint'(ram_addr), issue_idx);
        issue_idx++;
        check("credit_limit", longint'((outstanding - int'(out_valid && out_ready)) < 2), 1);
      end
      if (stall_prev) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_data", longint'(out_data), longint'(prev_data));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_output: got data %0d, expected no output (cycle %0d)", out_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", longint'(out_data), longint'(mon_e.data));
          check("out_last", longint'(out_last), longint'(mon_e.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      outstanding += int'(ram_en) - int'(out_valid && out_ready);
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input int kind);
    for (int i = 0; i < 256; i++)
      mem[i] = (kind == 0) ? DW'(i + 100) : ((i % 2 == 0) ? DW'(32'h8000 + i) : DW'(i));
  endtask

  task automatic load_exp(input int kind);
    exp_t x;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      if (kind == 0) x.data = DW'(i + 100);
`ifdef POOL_READER_RELU_EN
      else x.data = (i % 2 == 0) ? DW'(0) : DW'(i);
`else
      else x.data = (i % 2 == 0) ? DW'(32'h8000 + i) : DW'(i);
`endif
      x.last = (i == N - 1);
      sb.push_back(x);
    end
  endtask

  task automatic begin_xfer();
    first_valid_cyc = -1;
    hs_cnt    = 0;
    issue_idx = 0;
    start     = 1'b1;
    s_cyc     = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check("done_seen", longint'(done_cnt != d0), 1);
  endtask

  task automatic full_stream(input int kind);
    load_mem(kind);
    load_exp(kind);
    out_ready = 1'b1;
    begin_xfer();
    wait_done(400);
    check("first_valid_latency", first_valid_cyc - s_cyc, 3);
    check("done_cycle", done_cyc - s_cyc, 199);
    check("busy_at_done", longint'(busy_at_done), 0);
    check("handshakes", hs_cnt, N);
    check("sb_empty", sb.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    int r;
    int d0;
    repeat (3) step();
    check("reset_outputs", longint'({ram_en, ram_addr, out_data, out_valid, out_last, busy, done}), 0);
    rst = 1'b0;
    step();

    full_stream(0);

    // pseudo-random backpressure
    load_exp(0);
    d0 = done_cnt;
    rmode = 1;
    begin_xfer();
    wait_done(3000);
    rmode = 0;
    out_ready = 1'b1;
    check("rand_handshakes", hs_cnt, N);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_done_count", done_cnt - d0, 1);
    repeat (3) step();

    // held stall then release
    load_exp(0);
    out_ready = 1'b0;
    begin_xfer();
    repeat (19) step();
    check("stall_reads_issued", issue_idx, 2);
    check("stall_valid_held", longint'(out_valid), 1);
    check("stall_head_data", longint'(out_data), 100);
    out_ready = 1'b1;
    r = cyc;
    wait_done(400);
    check("release_full_rate", done_cyc - r, 196);
    check("stall_handshakes", hs_cnt, N);
    check("stall_sb_empty", sb.size(), 0);
    repeat (3) step();

    // second start while busy is ignored
    load_exp(0);
    d0 = done_cnt;
    begin_xfer();
    repeat (49) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(400);
    repeat (10) step();
    check("restart_done_count", done_cnt - d0, 1);
    check("restart_handshakes", hs_cnt, N);
    check("restart_done_cycle", done_cyc - s_cyc, 199);
    check("restart_sb_empty", sb.size(), 0);

    // reset mid-transfer
    load_exp(0);
    begin_xfer();
    repeat (79) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check("midreset_outputs", longint'({ram_en, ram_addr, out_data, out_valid, out_last, busy, done}), 0);
    repeat (3) step();
    full_stream(0);

    // sign-bit pattern: ReLU when enabled, raw otherwise
    full_stream(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
